// File: rtl/nic_cpu_core.sv
// nic_cpu_core: parametrised multi-cycle accumulator CPU (successor of nic8).
// Registers A, B, X, Q, PC, IR, OPND and carry; FSM FETCH/IMM/MEMRD/EXEC/STORE/HALT.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   ibus_req/addr         - instruction read request and address (PC)
//   ibus_ready/rdata      - instruction handshake; opcode is rdata[7:0]
//   dbus_rd/wr/addr/wdata - data read/write request, address (X), write data
//   dbus_ready/rdata      - data handshake and read value
//   qreg, q_strobe        - output register Q and a pulse the cycle after each Q write
//   halted                - high while in HALT
module nic_cpu_core #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ibus_req,
  output logic [AW-1:0]    ibus_addr,
  input  logic             ibus_ready,
  input  logic [WIDTH-1:0] ibus_rdata,
  output logic             dbus_rd,
  output logic             dbus_wr,
  output logic [WIDTH-1:0] dbus_addr,
  output logic [WIDTH-1:0] dbus_wdata,
  input  logic             dbus_ready,
  input  logic [WIDTH-1:0] dbus_rdata,
  output logic [WIDTH-1:0] qreg,
  output logic             q_strobe,
  output logic             halted
);

  localparam int unsigned OPW = 8;

  localparam logic [2:0] OP_LD   = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_JMP  = 3'd3;
  localparam logic [2:0] OP_ST   = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  localparam logic [1:0] SRC_IMM = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_A   = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_IMM,
    S_MEMRD,
    S_EXEC,
    S_STORE,
    S_HALT
  } state_t;

  state_t           state;
  state_t           nextState;
  logic [AW-1:0]    pc;
  logic [OPW-1:0]   ir;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] regX;
  logic [WIDTH-1:0] regQ;
  logic [WIDTH-1:0] opnd;
  logic             carry;

  logic [2:0]       irOp;
  logic [1:0]       irSrc;
  logic [2:0]       irDst;
  logic [2:0]       fetchOp;
  logic [1:0]       fetchSrc;
  logic             ibusAcc;
  logic             dbusAcc;
  logic             zero;
  logic [WIDTH-1:0] srcVal;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] result;
  logic             jmpTaken;

  // Only LD, JMP and ST have an operand phase.
  function automatic logic usesSrc(input logic [2:0] op);
    return (op == OP_LD) || (op == OP_JMP) || (op == OP_ST);
  endfunction

  assign irOp     = ir[7:5];
  assign irSrc    = ir[4:3];
  assign irDst    = ir[2:0];
  assign fetchOp  = ibus_rdata[7:5];
  assign fetchSrc = ibus_rdata[4:3];

  // A handshake completes only while our own request is up.
  assign ibusAcc = ibus_req && ibus_ready;
  assign dbusAcc = (dbus_rd || dbus_wr) && dbus_ready;

  assign zero = (regA == '0);
  assign sum  = {1'b0, regA} + {1'b0, regB};
  assign diff = {1'b0, regA} + {1'b0, ~regB} + (WIDTH+1)'(1);

  // Bus outputs are straight register views.
  assign ibus_addr  = pc;
  assign dbus_addr  = regX;
  assign dbus_wdata = opnd;
  assign qreg       = regQ;

  // Operand selection: imm and mem both land in OPND beforehand.
  always_comb begin
    srcVal = opnd;
    case (irSrc)
      SRC_IMM, SRC_MEM: srcVal = opnd;
      SRC_A:            srcVal = regA;
      default:          srcVal = regB;
    endcase
  end

  // Writeback value for LD/ADD/SUB.
  always_comb begin
    result = srcVal;
    case (irOp)
      OP_ADD:  result = sum[WIDTH-1:0];
      OP_SUB:  result = diff[WIDTH-1:0];
      default: result = srcVal;
    endcase
  end

  // Jump condition lives in the dst field.
  always_comb begin
    jmpTaken = 1'b0;
    case (irDst)
      3'd0:    jmpTaken = 1'b1;
      3'd1:    jmpTaken = zero;
      3'd2:    jmpTaken = carry;
      3'd3:    jmpTaken = !zero;
      default: jmpTaken = 1'b0;
    endcase
  end

  // Next-state decode.
  always_comb begin
    nextState = state;
    case (state)
      S_FETCH: begin
        if (ibusAcc) begin
          if (usesSrc(fetchOp) && (fetchSrc == SRC_IMM)) begin
            nextState = S_IMM;
          end else if (usesSrc(fetchOp) && (fetchSrc == SRC_MEM)) begin
            nextState = S_MEMRD;
          end else begin
            nextState = S_EXEC;
          end
        end
      end
      S_IMM:   if (ibusAcc) nextState = S_EXEC;
      S_MEMRD: if (dbusAcc) nextState = S_EXEC;
      S_EXEC: begin
        if (irOp == OP_ST) begin
          nextState = S_STORE;
        end else if (irOp == OP_HALT) begin
          nextState = S_HALT;
        end else begin
          nextState = S_FETCH;
        end
      end
      S_STORE: if (dbusAcc) nextState = S_FETCH;
      S_HALT:  nextState = S_HALT;
      default: nextState = S_FETCH;
    endcase
  end

  // State, datapath and registered request outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      regA     <= '0;
      regB     <= '0;
      regX     <= '0;
      regQ     <= '0;
      opnd     <= '0;
      carry    <= 1'b0;
      ibus_req <= 1'b0;
      dbus_rd  <= 1'b0;
      dbus_wr  <= 1'b0;
      q_strobe <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= nextState;
      // Requests follow the state being entered, so they are up for its whole stay.
      ibus_req <= (nextState == S_FETCH) || (nextState == S_IMM);
      dbus_rd  <= (nextState == S_MEMRD);
      dbus_wr  <= (nextState == S_STORE);
      halted   <= (nextState == S_HALT);
      q_strobe <= 1'b0;

      case (state)
        S_FETCH: begin
          if (ibusAcc) begin
            ir <= ibus_rdata[OPW-1:0];
            pc <= pc + AW'(1);
          end
        end
        S_IMM: begin
          if (ibusAcc) begin
            opnd <= ibus_rdata;
            pc   <= pc + AW'(1);
          end
        end
        S_MEMRD: begin
          if (dbusAcc) opnd <= dbus_rdata;
        end
        S_EXEC: begin
          case (irOp)
            OP_LD, OP_ADD, OP_SUB: begin
              case (irDst)
                3'd0: regA <= result;
                3'd1: regB <= result;
                3'd2: regX <= result;
                3'd3: begin
                  regQ     <= result;
                  q_strobe <= 1'b1;
                end
                default: ;
              endcase
              if (irOp == OP_ADD) carry <= sum[WIDTH];
              if (irOp == OP_SUB) carry <= diff[WIDTH];
            end
            OP_JMP: begin
              if (jmpTaken) pc <= AW'(srcVal);
            end
            OP_ST: begin
              // Latch store data here so STORE can hold it stable across waits.
              opnd <= srcVal;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
